// File: rtl/reg_wbus_arbiter_pkg.sv
// rtl/reg_wbus_arbiter_pkg.sv - shared state encoding, owner width and one-hot decode helper
// Purpose: common definitions for the write-bus arbiter slice.
// Ports: none (package).
package reg_wbus_arbiter_pkg;

    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BLOCK = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Index of the highest set bit of a one-hot vector (up to 8 masters).
    function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = OWNER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_wbus_arbiter_if.sv
// rtl/reg_wbus_arbiter_if.sv - per-master request/strobe/grant bundle
// Purpose: groups the N write masters' request, strobe, address and data lines plus the grant.
// Ports (signals): m_req, m_reg_wen, m_blk_wen, m_blk_wstart (N each), m_waddr (N*ADDR_W),
//   m_wdata (N*DATA_W), m_grant (N, driven by the arbiter).
// Modports: master (write-master side), slave (arbiter side).
interface reg_wbus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_reg_wen;
    logic [NUM_MASTERS-1:0]        m_blk_wen;
    logic [NUM_MASTERS-1:0]        m_blk_wstart;
    logic [NUM_MASTERS*ADDR_W-1:0] m_waddr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_grant;

    modport master (
        output m_req, m_reg_wen, m_blk_wen, m_blk_wstart, m_waddr, m_wdata,
        input  m_grant
    );

    modport slave (
        input  m_req, m_reg_wen, m_blk_wen, m_blk_wstart, m_waddr, m_wdata,
        output m_grant
    );
endinterface

// File: rtl/reg_wbus_arbiter_prio_pick.sv
// rtl/reg_wbus_arbiter_prio_pick.sv - combinational rotating one-hot request picker
// Purpose: returns the first set request found searching upward from 'start', wrapping at N.
// Ports: req (N) request vector, start (OWNER_W) first index searched, pick (N) one-hot winner.
module wbus_prio_pick
    import reg_wbus_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] start,
    output logic [N-1:0]       pick
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] rot_dbl;
    logic [2*N-1:0] pick_dbl;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_pick;

    // Rotate so 'start' sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req};
        rot_dbl  = req_dbl >> start;
        rot_req  = rot_dbl[N-1:0];
        rot_pick = rot_req & (~rot_req + N'(1));
        pick_dbl = {rot_pick, rot_pick} << start;
        pick     = pick_dbl[2*N-1:N];
    end

endmodule

// File: rtl/reg_wbus_arbiter.sv
// rtl/reg_wbus_arbiter.sv - N-master register write-bus arbiter with atomic block writes
// Purpose: grants one write master at a time, holds block writes atomic, muxes the owner onto
//   the shared write bus and keeps block-timeout / dropped-strobe diagnostics.
// Ports: sysclk, rst_n (async active-low); wif (slave modport: per-master req/strobes/addr/data,
//   grant out); reg_wen/blk_wen/blk_wstart/reg_waddr/reg_wdata arbitrated bus; owner, busy;
//   blk_timeout (sticky), drop_count (saturating); status_clr clears both.
// Config: WBUS_RR_EN selects round-robin arbitration; undefined gives fixed priority (index 0 first).
module reg_wbus_arbiter
    import reg_wbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int BLK_TIMEOUT = 4096
) (
    input  logic               sysclk,
    input  logic               rst_n,
    reg_wbus_arbiter_if.slave  wif,
    output logic               reg_wen,
    output logic               blk_wen,
    output logic               blk_wstart,
    output logic [ADDR_W-1:0]  reg_waddr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic [OWNER_W-1:0] owner,
    output logic               busy,
    output logic               blk_timeout,
    output logic [7:0]         drop_count,
    input  logic               status_clr
);

    localparam int N  = NUM_MASTERS;
    localparam int TW = $clog2(BLK_TIMEOUT);

    state_e             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         drop_q, drop_d;

    logic [N-1:0]       pick;
    logic [OWNER_W-1:0] pick_start;
    logic               own_req;
    logic [N-1:0]       strobes;
    logic [N-1:0]       foreign;

`ifdef WBUS_RR_EN
    logic [OWNER_W-1:0] last_q, last_d;
    assign pick_start = (last_q == OWNER_W'(N-1)) ? '0 : last_q + OWNER_W'(1);
`else
    assign pick_start = '0;
`endif

    wbus_prio_pick #(.N(N)) u_pick (
        .req   (wif.m_req),
        .start (pick_start),
        .pick  (pick)
    );

    // grant_q is all-zero whenever busy is low, so masking with it also gates by busy.
    always_comb begin
        own_req    = |(wif.m_req        & grant_q);
        reg_wen    = |(wif.m_reg_wen    & grant_q);
        blk_wen    = |(wif.m_blk_wen    & grant_q);
        blk_wstart = |(wif.m_blk_wstart & grant_q);
        reg_waddr  = '0;
        reg_wdata  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                reg_waddr = wif.m_waddr[i*ADDR_W +: ADDR_W];
                reg_wdata = wif.m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`ifdef WBUS_RR_EN
        last_d    = last_q;
`endif
        // A timeout in the same cycle as a clear still records (set overrides below).
        if (status_clr) timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|wif.m_req) begin
                    state_d = ST_GRANT;
                    grant_d = pick;
                    owner_d = onehot_to_idx(8'(pick));
`ifdef WBUS_RR_EN
                    last_d  = onehot_to_idx(8'(pick));
`endif
                end
            end
            ST_GRANT: begin
                // Start and end together is a zero-length block: stay in GRANT.
                if (blk_wstart && !blk_wen) begin
                    state_d = ST_BLOCK;
                    cnt_d   = '0;
                end else if (!own_req) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                end
            end
            ST_BLOCK: begin
                if (blk_wen) begin
                    if (own_req) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_GAP;
                        grant_d = '0;
                    end
                end else if (blk_wstart) begin
                    cnt_d = '0;
                end else if (cnt_q == TW'(BLK_TIMEOUT-1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_GAP;
                    grant_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Any strobe from a master not holding the grant is a lost write.
    always_comb begin
        strobes = wif.m_reg_wen | wif.m_blk_wen | wif.m_blk_wstart;
        foreign = strobes & ~grant_q;
        drop_d  = drop_q;
        if (status_clr) begin
            drop_d = '0;
        end else if (|foreign && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
`ifdef WBUS_RR_EN
            last_q    <= OWNER_W'(N-1);
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
`ifdef WBUS_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign wif.m_grant = grant_q;
    assign owner       = owner_q;
    assign busy        = |grant_q;
    assign blk_timeout = timeout_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_reg_wbus_arbiter.sv
// tb/tb_reg_wbus_arbiter.sv - self-checking bench for reg_wbus_arbiter
module tb_reg_wbus_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        reg_wen, blk_wen, blk_wstart;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic [2:0]  owner;
    logic        busy, blk_timeout;
    logic [7:0]  drop_count;
    logic        status_clr;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, whether a block is open and since when,
    // whether the dead cycle after a release is still pending, and the diagnostics.
    int  mo;
    int  mlast;
    int  t0;
    int  cyc;
    int  mdrop;
    bit  mblk;
    bit  mgap;
    bit  mto;

    logic [47:0] cur_addr;
    logic [95:0] cur_data;
    logic [2:0]  cur_rw, cur_bw, cur_bs;

    always #5 sysclk = ~sysclk;

    reg_wbus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) wif ();

    reg_wbus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BLK_TIMEOUT (TO)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .wif         (wif),
        .reg_wen     (reg_wen),
        .blk_wen     (blk_wen),
        .blk_wstart  (blk_wstart),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .owner       (owner),
        .busy        (busy),
        .blk_timeout (blk_timeout),
        .drop_count  (drop_count),
        .status_clr  (status_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_master(input logic [2:0] r);
`ifdef WBUS_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(mlast + k) % N]) return (mlast + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic void model_reset();
        mo = -1; mlast = N - 1; t0 = 0; cyc = 0; mdrop = 0;
        mblk = 1'b0; mgap = 1'b0; mto = 1'b0;
    endfunction

    function automatic void model_release();
        mo = -1; mblk = 1'b0; mgap = 1'b1;
    endfunction

    function automatic void model_edge(input logic [2:0] req, rw, bw, bs, input logic clr);
        logic [2:0] stb, foreign;
        logic       oreq, ws, we;
        cyc++;
        stb     = rw | bw | bs;
        foreign = (mo < 0) ? stb : (stb & ~3'(1 << mo));
        if (clr) mdrop = 0;
        else if (foreign != 3'b0 && mdrop < 255) mdrop++;
        if (clr) mto = 1'b0;
        if (mo < 0) begin
            if (mgap) mgap = 1'b0;
            else if (req != 3'b0) begin
                mo = pick_master(req);
                mlast = mo;
            end
        end else begin
            oreq = 1'(req >> mo);
            ws   = 1'(bs >> mo);
            we   = 1'(bw >> mo);
            if (!mblk) begin
                if (ws && !we) begin
                    mblk = 1'b1;
                    t0   = cyc;
                end else if (!oreq) model_release();
            end else if (we) begin
                mblk = 1'b0;
                if (!oreq) model_release();
            end else if (ws) begin
                t0 = cyc;
            end else if (cyc - t0 >= TO) begin
                mto = 1'b1;
                model_release();
            end
        end
    endfunction

    task automatic check_bus();
        logic        ew, ebw, ebs;
        logic [15:0] ea;
        logic [31:0] ed;
        ew = 1'b0; ebw = 1'b0; ebs = 1'b0; ea = '0; ed = '0;
        if (mo >= 0) begin
            ew  = 1'(cur_rw >> mo);
            ebw = 1'(cur_bw >> mo);
            ebs = 1'(cur_bs >> mo);
            ea  = 16'(cur_addr >> (mo * AW));
            ed  = 32'(cur_data >> (mo * DW));
        end
        chk("bus_reg_wen",    64'(reg_wen),    64'(ew));
        chk("bus_blk_wen",    64'(blk_wen),    64'(ebw));
        chk("bus_blk_wstart", 64'(blk_wstart), 64'(ebs));
        chk("bus_waddr",      64'(reg_waddr),  64'(ea));
        chk("bus_wdata",      64'(reg_wdata),  64'(ed));
    endtask

    task automatic check_regs();
        logic [2:0] eg;
        eg = (mo >= 0) ? 3'(1 << mo) : 3'b0;
        chk("grant",       64'(wif.m_grant), 64'(eg));
        chk("busy",        64'(busy),        64'(mo >= 0));
        if (mo >= 0) chk("owner", 64'(owner), 64'(mo));
        chk("drop_count",  64'(drop_count),  64'(mdrop));
        chk("blk_timeout", 64'(blk_timeout), 64'(mto));
    endtask

    task automatic cycle(input logic [2:0] req, rw, bw, bs, input logic clr);
        logic [63:0] a64;
        a64      = {$urandom(), $urandom()};
        cur_addr = a64[47:0];
        cur_data = {$urandom(), $urandom(), $urandom()};
        cur_rw = rw; cur_bw = bw; cur_bs = bs;
        wif.m_req        = req;
        wif.m_reg_wen    = rw;
        wif.m_blk_wen    = bw;
        wif.m_blk_wstart = bs;
        wif.m_waddr      = cur_addr;
        wif.m_wdata      = cur_data;
        status_clr       = clr;
        #1;
        check_bus();
        @(posedge sysclk);
        model_edge(req, rw, bw, bs, clr);
        #1;
        check_regs();
    endtask

    initial begin
        logic [2:0] rq, rrw, rbw, rbs;
        logic       rclr;

        wif.m_req = '0; wif.m_reg_wen = '0; wif.m_blk_wen = '0; wif.m_blk_wstart = '0;
        wif.m_waddr = '0; wif.m_wdata = '0; status_clr = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_grant",   64'(wif.m_grant), 64'(0));
        chk("rst_busy",    64'(busy),        64'(0));
        chk("rst_owner",   64'(owner),       64'(0));
        chk("rst_reg_wen", 64'(reg_wen),     64'(0));
        chk("rst_waddr",   64'(reg_waddr),   64'(0));
        chk("rst_wdata",   64'(reg_wdata),   64'(0));
        chk("rst_drop",    64'(drop_count),  64'(0));
        chk("rst_timeout", 64'(blk_timeout), 64'(0));
        rst_n = 1'b1;

        // Priority: 110 -> master 1; dropping it hands over to master 2 three edges later
        cycle(3'b110, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("prio_grant1", 64'(wif.m_grant), 64'(3'b010));
        cycle(3'b110, 3'b010, 3'b000, 3'b000, 1'b0);
        cycle(3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("prio_release", 64'(wif.m_grant), 64'(3'b000));
        cycle(3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("prio_gap", 64'(wif.m_grant), 64'(3'b000));
        cycle(3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("prio_grant2", 64'(wif.m_grant), 64'(3'b100));

        // Atomic block by master 2: request dropped inside the block, released on blk_wen
        cycle(3'b100, 3'b000, 3'b000, 3'b100, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            chk("blk_held", 64'(wif.m_grant), 64'(3'b100));
        end
        cycle(3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
        chk("blk_released", 64'(wif.m_grant), 64'(3'b000));
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Block timeout for master 0, then status clear
        cycle(3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        cycle(3'b001, 3'b000, 3'b000, 3'b001, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            cycle(3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
            chk("to_grant", 64'(wif.m_grant), (k < TO) ? 64'(1) : 64'(0));
        end
        chk("to_flag_set", 64'(blk_timeout), 64'(1));
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("to_flag_clr", 64'(blk_timeout), 64'(0));
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Drops: master 1 strobes for 300 cycles while master 0 owns the bus
        cycle(3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 300; k++) cycle(3'b011, 3'b011, 3'b000, 3'b000, 1'b0);
        chk("drop_sat", 64'(drop_count), 64'(255));
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("drop_clr", 64'(drop_count), 64'(0));
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Reset in the middle of a block drops the grant without a clock edge
        cycle(3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
        cycle(3'b010, 3'b000, 3'b000, 3'b010, 1'b0);
        cycle(3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_grant", 64'(wif.m_grant), 64'(0));
        chk("rstmid_busy",  64'(busy),        64'(0));
        model_reset();
        @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        cycle(3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
        chk("rstmid_regrant", 64'(wif.m_grant), 64'(3'b010));
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        cycle(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

        // Random traffic against the model
        rq = 3'b000;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) rq[i] = ~rq[i];
                rrw[i] = ($urandom_range(0, 4) == 0);
                rbs[i] = ($urandom_range(0, 19) == 0);
                rbw[i] = ($urandom_range(0, 24) == 0);
            end
            rclr = ($urandom_range(0, 59) == 0);
            cycle(rq, rrw, rbw, rbs, rclr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
